// File: rtl/clock_gate_sequencer_if.sv
// Request/status bundle between requesting masters and clock_gate_sequencer.
// The sequencer connects through the slave modport; masters use the master modport.
interface clock_gate_sequencer_if #(
  parameter int N_DOM  = 4,
  parameter int IDLE_W = 8
);
  logic [N_DOM-1:0]  req;
  logic [N_DOM-1:0]  busy;
  logic [IDLE_W-1:0] idle_thresh;
  logic              force_on;
  logic [N_DOM-1:0]  cg_en;
  logic [N_DOM-1:0]  ready;
  logic [N_DOM-1:0]  wake_gnt;

  modport master (
    output req, busy, idle_thresh, force_on,
    input  cg_en, ready, wake_gnt
  );

  modport slave (
    input  req, busy, idle_thresh, force_on,
    output cg_en, ready, wake_gnt
  );
endinterface

// File: rtl/clock_gate_sequencer.sv
// ICG enable controller: round-robin serialised wake-up, idle-timeout gating per domain.
// Optional CG_STATS_EN adds per-domain saturating gated-cycle counters (stat_clr, gated_cycles).
module clock_gate_sequencer #(
  parameter int N_DOM    = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  clock_gate_sequencer_if.slave  cg_if
`ifdef CG_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [N_DOM*16-1:0]    gated_cycles
`endif
);

  localparam int PTR_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam int WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [PTR_W:0]    N_DOM_W  = (PTR_W+1)'(N_DOM);
  localparam logic [WCNT_W-1:0] WAKE_END = WCNT_W'(WAKE_LAT - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAKING = 2'd1,
    ST_ON     = 2'd2
  } dom_state_t;

  logic [N_DOM-1:0] cand;
  logic [N_DOM-1:0] gnt;
  logic [N_DOM-1:0] cg_en_int;
  logic [N_DOM-1:0] ready_int;
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  // First candidate at or after the pointer wins; pointer advances past the grantee.
  always_comb begin
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    gnt      = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N_DOM; k++) begin
      sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (sum >= N_DOM_W) begin
        sum = sum - N_DOM_W;
      end
      idx = sum[PTR_W-1:0];
      if (!found && cand[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_next = (sum == N_DOM_W - 1'b1) ? '0 : PTR_W'(sum + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_DOM; gi++) begin : g_dom
      dom_state_t        state_reg;
      logic [WCNT_W-1:0] wake_cnt_reg;
      logic [IDLE_W-1:0] idle_cnt_reg;
      logic              cg_en_reg;
      logic              ready_reg;
      logic              active;
      logic              idle_expired;

      assign active = cg_if.req[gi] | cg_if.busy[gi];
      // Compared live so a lowered threshold takes effect on the next idle cycle.
      assign idle_expired = (cg_if.idle_thresh != '0) &&
                            (idle_cnt_reg >= (cg_if.idle_thresh - IDLE_W'(1)));

      // Reset masks candidates so wake_gnt stays low while rst_n is asserted.
      assign cand[gi]      = rst_n & cg_if.req[gi] & (state_reg == ST_OFF);
      assign cg_en_int[gi] = cg_en_reg;
      assign ready_int[gi] = ready_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg    <= ST_OFF;
          wake_cnt_reg <= '0;
          idle_cnt_reg <= '0;
          cg_en_reg    <= 1'b0;
          ready_reg    <= 1'b0;
        end else begin
          case (state_reg)
            ST_OFF: begin
              if (gnt[gi]) begin
                state_reg    <= ST_WAKING;
                wake_cnt_reg <= '0;
                cg_en_reg    <= 1'b1;
              end
            end
            ST_WAKING: begin
              if (wake_cnt_reg == WAKE_END) begin
                state_reg    <= ST_ON;
                ready_reg    <= 1'b1;
                idle_cnt_reg <= '0;
              end else begin
                wake_cnt_reg <= wake_cnt_reg + 1'b1;
              end
            end
            ST_ON: begin
              if (active) begin
                idle_cnt_reg <= '0;
              end else if (idle_expired) begin
                state_reg    <= ST_OFF;
                cg_en_reg    <= 1'b0;
                ready_reg    <= 1'b0;
                idle_cnt_reg <= '0;
              end else if (idle_cnt_reg != '1) begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
              end
            end
            default: begin
              state_reg <= ST_OFF;
              cg_en_reg <= 1'b0;
              ready_reg <= 1'b0;
            end
          endcase
        end
      end

`ifdef CG_STATS_EN
      logic [15:0] gated_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gated_reg <= '0;
        end else if (stat_clr) begin
          gated_reg <= '0;
        end else if ((state_reg == ST_OFF) && !cg_if.force_on && (gated_reg != 16'hFFFF)) begin
          gated_reg <= gated_reg + 16'd1;
        end
      end

      assign gated_cycles[gi*16 +: 16] = gated_reg;
`endif
    end
  endgenerate

  assign cg_if.cg_en    = cg_en_int | {N_DOM{cg_if.force_on}};
  assign cg_if.ready    = ready_int;
  assign cg_if.wake_gnt = gnt;

endmodule

// File: tb/tb_clock_gate_sequencer.sv
// Directed bench for clock_gate_sequencer (N_DOM=4, IDLE_W=8, WAKE_LAT=2).
// Stats checks are compiled in only when CG_STATS_EN is defined.
module tb_clock_gate_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  clock_gate_sequencer_if #(.N_DOM(4), .IDLE_W(8)) dut_if ();

`ifdef CG_STATS_EN
  logic        stat_clr;
  logic [63:0] gated_cycles;
`endif

  clock_gate_sequencer #(.N_DOM(4), .IDLE_W(8), .WAKE_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cg_if (dut_if)
`ifdef CG_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .gated_cycles (gated_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] busy;
    logic       force_on;
    logic [7:0] thresh;
    logic [3:0] exp_cg;
    logic [3:0] exp_rdy;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dut_if.req = '0;
    dut_if.busy = '0;
    dut_if.force_on = 1'b0;
    dut_if.idle_thresh = 8'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Grant domain 0, wait for ready, then leave the next cycle as idle cycle 1.
  task automatic wake_dom0();
    @(negedge clk);
    dut_if.req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    dut_if.req = 4'b0000;
    #1;
    check("wake_ready0", {28'd0, dut_if.ready}, 32'h1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef CG_STATS_EN
    stat_clr = 1'b0;
`endif
    rst_n = 1'b0;
    dut_if.req = '0;
    dut_if.busy = '0;
    dut_if.force_on = 1'b0;
    dut_if.idle_thresh = 8'd0;
    #1;
    check("reset_state", {20'd0, dut_if.cg_en, dut_if.ready, dut_if.wake_gnt}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("idle_after_reset", {20'd0, dut_if.cg_en, dut_if.ready, dut_if.wake_gnt}, 32'h0);
    end

    //           req      busy     f     thr    cg       rdy      gnt
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 8'd3, 4'b0000, 4'b0000, 4'b0010};
    tbl[2]  = '{4'b0010, 4'b0000, 1'b0, 8'd3, 4'b0010, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b0010, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b0010, 4'b0010, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b0010, 4'b0010, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b0010, 4'b0010, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0010, 1'b0, 8'd3, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1111, 4'b0000, 1'b0, 8'd3, 4'b0000, 4'b0000, 4'b0100};
    tbl[10] = '{4'b1111, 4'b0000, 1'b0, 8'd3, 4'b0100, 4'b0000, 4'b1000};
    tbl[11] = '{4'b1111, 4'b0000, 1'b0, 8'd3, 4'b1100, 4'b0000, 4'b0001};
    tbl[12] = '{4'b1111, 4'b0000, 1'b0, 8'd3, 4'b1101, 4'b0100, 4'b0010};
    tbl[13] = '{4'b1111, 4'b0000, 1'b0, 8'd3, 4'b1111, 4'b1100, 4'b0000};
    tbl[14] = '{4'b1111, 4'b0000, 1'b0, 8'd3, 4'b1111, 4'b1101, 4'b0000};
    tbl[15] = '{4'b1111, 4'b0000, 1'b0, 8'd3, 4'b1111, 4'b1111, 4'b0000};
    tbl[16] = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b1111, 4'b1111, 4'b0000};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b1111, 4'b1111, 4'b0000};
    tbl[18] = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b1111, 4'b1111, 4'b0000};
    tbl[19] = '{4'b0000, 4'b0000, 1'b1, 8'd3, 4'b1111, 4'b0000, 4'b0000};
    tbl[20] = '{4'b0000, 4'b0000, 1'b0, 8'd3, 4'b0000, 4'b0000, 4'b0000};

    for (int r = 0; r < 21; r++) begin
      @(negedge clk);
      dut_if.req = tbl[r].req;
      dut_if.busy = tbl[r].busy;
      dut_if.force_on = tbl[r].force_on;
      dut_if.idle_thresh = tbl[r].thresh;
      #1;
      $display("vec %0d req=%b busy=%b force=%b cg_en=%b ready=%b wake_gnt=%b", r,
               tbl[r].req, tbl[r].busy, tbl[r].force_on,
               dut_if.cg_en, dut_if.ready, dut_if.wake_gnt);
      check("vec_cg_en", {28'd0, dut_if.cg_en}, {28'd0, tbl[r].exp_cg});
      check("vec_ready", {28'd0, dut_if.ready}, {28'd0, tbl[r].exp_rdy});
      check("vec_wake_gnt", {28'd0, dut_if.wake_gnt}, {28'd0, tbl[r].exp_gnt});
    end

    // All requesting from pointer 0, then 0101 from pointer 0
    do_reset();
    dut_if.idle_thresh = 8'd1;
    dut_if.req = 4'b1111;
    #1;
    check("rr_all_0", {28'd0, dut_if.wake_gnt}, 32'h1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("rr_all_n", {28'd0, dut_if.wake_gnt}, 32'h1 << i);
    end
    @(negedge clk);
    dut_if.req = 4'b0000;
    repeat (10) @(negedge clk);
    #1;
    check("rr_all_gated", {28'd0, dut_if.cg_en}, 32'h0);
    dut_if.req = 4'b0101;
    #1;
    check("rr_0101_first", {28'd0, dut_if.wake_gnt}, 32'h1);
    @(negedge clk);
    #1;
    check("rr_0101_second", {28'd0, dut_if.wake_gnt}, 32'h4);
    dut_if.req = 4'b0000;

    // Exact idle period of 5 cycles
    do_reset();
    dut_if.idle_thresh = 8'd5;
    wake_dom0();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("idle5_open", {31'd0, dut_if.cg_en[0]}, 32'h1);
      @(negedge clk);
    end
    #1;
    check("idle5_closed", {31'd0, dut_if.cg_en[0]}, 32'h0);

    // Busy on idle cycle 4 restarts the count
    wake_dom0();
    for (int i = 0; i < 9; i++) begin
      dut_if.busy = (i == 3) ? 4'b0001 : 4'b0000;
      #1;
      check("busy_restart_open", {31'd0, dut_if.cg_en[0]}, 32'h1);
      @(negedge clk);
    end
    dut_if.busy = 4'b0000;
    #1;
    check("busy_restart_closed", {31'd0, dut_if.cg_en[0]}, 32'h0);

    // Threshold lowered below the running count gates on the next idle cycle
    dut_if.idle_thresh = 8'd20;
    wake_dom0();
    repeat (6) @(negedge clk);
    dut_if.idle_thresh = 8'd3;
    #1;
    check("live_thresh_open", {31'd0, dut_if.cg_en[0]}, 32'h1);
    @(negedge clk);
    #1;
    check("live_thresh_closed", {31'd0, dut_if.cg_en[0]}, 32'h0);

    // Threshold 0 never gates; counter saturates rather than wrapping
    dut_if.idle_thresh = 8'd0;
    wake_dom0();
    repeat (300) @(negedge clk);
    #1;
    check("thresh0_open", {28'd0, dut_if.cg_en}, 32'h1);
    check("thresh0_ready", {28'd0, dut_if.ready}, 32'h1);
    dut_if.idle_thresh = 8'd200;
    @(negedge clk);
    #1;
    check("saturate_gate", {31'd0, dut_if.cg_en[0]}, 32'h0);

    // Async reset in WAKING
    do_reset();
    dut_if.req = 4'b0001;
    @(negedge clk);
    #1;
    check("waking_cg_en", {28'd0, dut_if.cg_en}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {20'd0, dut_if.cg_en, dut_if.ready, dut_if.wake_gnt}, 32'h0);
    @(negedge clk);
    dut_if.req = 4'b0000;
    rst_n = 1'b1;

`ifdef CG_STATS_EN
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("stat_clr_zero", gated_cycles[31:0], 32'h0);
    repeat (100) @(negedge clk);
    #1;
    check("stat_100", {16'd0, gated_cycles[15:0]}, 32'd100);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("stat_clr", {16'd0, gated_cycles[15:0]}, 32'd0);
    repeat (70000) @(negedge clk);
    #1;
    check("stat_saturate", {16'd0, gated_cycles[15:0]}, 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
